bht_update_sched: RTL and testbench

// Sequences all writes to the branch history table storage (one row = INSTR_PER_FETCH 3-bit {valid,ctr[1:0]} entries).

---
 rtl/bht_sched_pkg.sv | 12 +
 rtl/bht_upd_fifo.sv | 39 +++
 rtl/bht_update_sched.sv | 132 +++++++++++++
 tb/tb_bht_update_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bht_sched_pkg.sv
// bht_sched_pkg: shared types, constants and counter helper for the BHT update scheduler
package bht_sched_pkg;
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bht_entry_t;
  typedef enum logic {IDLE, FLUSH} sched_state_e;
  localparam logic [1:0] FLUSH_CTR_INIT = 2'b10;
  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
    return taken ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo: synchronous FIFO with clear, wrap-around pointers carrying an extra MSB
//   clk_i/rst_i clock and sync active-high reset; clear_i empties the FIFO (a same-cycle push survives)
//   push_i/data_i enqueue; pop_i/data_o dequeue (data_o shows the head); full_o/empty_o status
module bht_upd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty_o = wptr == rptr;
  assign full_o = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign data_o = mem[rptr[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear_i) begin
      wptr <= {{AW{1'b0}}, push_i};
      rptr <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (pop_i) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem[clear_i ? '0 : wptr[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/bht_update_sched.sv
// bht_update_sched: sequences all BHT RAM writes (counter read-modify-write updates and flush sweep)
//   clk_i, rst_i (sync, active-high); flush_bp_i restarts the sweep; debug_mode_i blocks updates
//   upd_*: resolved branches from EXECUTE; ram_rd_*: 1-cycle-latency read port; ram_w*: write port
//   flush_busy_o: sweep in progress
//   Optional macro BHT_SCHED_STATS_EN adds stat_upd_o (writes applied) and stat_drop_o (updates lost)
module bht_update_sched
  import bht_sched_pkg::*;
#(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          RVC             = 1'b1,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned FIFO_DEPTH      = 4,
  localparam int unsigned IPF            = INSTR_PER_FETCH,
  localparam int unsigned ROW_W          = $clog2(NR_ENTRIES / INSTR_PER_FETCH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_bp_i,
  input  logic               debug_mode_i,
  input  logic               upd_valid_i,
  input  logic [VLEN-1:0]    upd_pc_i,
  input  logic               upd_taken_i,
  output logic               ram_rd_en_o,
  output logic [ROW_W-1:0]   ram_rd_addr_o,
  input  logic [IPF*3-1:0]   ram_rd_data_i,
  output logic               ram_we_o,
  output logic [ROW_W-1:0]   ram_wr_addr_o,
  output logic [IPF-1:0]     ram_wr_mask_o,
  output logic [IPF*3-1:0]   ram_wr_data_o,
  output logic               flush_busy_o
`ifdef BHT_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_upd_o,
  output logic [31:0]        stat_drop_o
`endif
);
  localparam int unsigned NR_ROWS = NR_ENTRIES / IPF;
  localparam int unsigned OFFSET = RVC ? 1 : 2;
  localparam int unsigned COL_W = $clog2(IPF);
  localparam int unsigned CW = COL_W > 0 ? COL_W : 1;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [CW-1:0]    col;
    logic             taken;
  } bht_upd_req_t;
  sched_state_e state_q, state_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  bht_upd_req_t push_req, head, s1_q;
  logic s1_valid_q, push, pop, full, empty, flushing, s1_we, fwd;
  logic lw_valid_q;
  logic [ROW_W-1:0] lw_row_q;
  logic [CW-1:0] lw_col_q;
  logic [1:0] lw_ctr_q, old_ctr, new_ctr;
  bht_entry_t wr_entry;
  logic unused_bits;
  assign unused_bits = ^{upd_pc_i, ram_rd_data_i};
  assign push_req.row = upd_pc_i[COL_W+OFFSET +: ROW_W];
  assign push_req.col = (RVC && COL_W > 0) ? upd_pc_i[OFFSET +: CW] : '0;
  assign push_req.taken = upd_taken_i;
  assign flushing = state_q == FLUSH;
  assign pop = !flushing && !flush_bp_i && !empty;
  // A flush clears the FIFO in the same cycle, so an incoming update always fits
  assign push = upd_valid_i && !debug_mode_i && (!full || pop || flush_bp_i);
  always_comb begin
    state_d = flush_bp_i ? FLUSH : (flushing && cnt_q == ROW_W'(NR_ROWS - 1)) ? IDLE : state_q;
    cnt_d = flush_bp_i ? '0 : flushing ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FLUSH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  bht_upd_fifo #(
    .WIDTH ($bits(bht_upd_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_bp_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_req),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // The RAM returns pre-write data on a same-cycle read/write, so the counter
  // written one cycle earlier must be forwarded instead of the RAM value
  assign fwd = lw_valid_q && lw_row_q == s1_q.row && lw_col_q == s1_q.col;
  assign old_ctr = fwd ? lw_ctr_q : ram_rd_data_i[3*s1_q.col +: 2];
  assign new_ctr = sat_upd(old_ctr, s1_q.taken);
  assign s1_we = s1_valid_q && !flush_bp_i && !flushing;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      lw_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= pop;
      lw_valid_q <= s1_we;
    end
    s1_q <= head;
    lw_row_q <= s1_q.row;
    lw_col_q <= s1_q.col;
    lw_ctr_q <= new_ctr;
  end
  assign wr_entry = flushing ? '{valid: 1'b0, ctr: FLUSH_CTR_INIT} : '{valid: 1'b1, ctr: new_ctr};
  assign ram_rd_en_o = !rst_i && pop;
  assign ram_rd_addr_o = head.row;
  assign ram_we_o = !rst_i && (flushing || s1_we);
  assign ram_wr_addr_o = flushing ? cnt_q : s1_q.row;
  assign ram_wr_mask_o = flushing ? '1 : IPF'(1) << s1_q.col;
  assign ram_wr_data_o = {IPF{wr_entry}};
  assign flush_busy_o = flushing;
`ifdef BHT_SCHED_STATS_EN
  logic drop;
  assign drop = upd_valid_i && !debug_mode_i && !push;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_upd_o <= '0;
      stat_drop_o <= '0;
    end else begin
      stat_upd_o <= stat_upd_o + 32'(s1_we);
      stat_drop_o <= stat_drop_o + 32'(drop);
    end
  end
`endif
endmodule

// File: tb/tb_bht_update_sched.sv
// tb_bht_update_sched: randomized and directed bench against a queue-based reference model
module tb_bht_update_sched;
  localparam int ROWS = 8;
  logic clk = 1'b0, rst = 1'b1, flush_bp = 1'b0, dbg = 1'b0, uv = 1'b0, ut = 1'b0;
  logic [31:0] upc = '0;
  logic rd_en, we, busy;
  logic [2:0] rd_addr, wr_addr;
  logic [1:0] mask;
  logic [5:0] rd_data = '0, wr_data;
`ifdef BHT_SCHED_STATS_EN
  logic [31:0] s_upd, s_drop;
`endif
  always #5 clk = ~clk;
  bht_update_sched #(
    .VLEN (32), .INSTR_PER_FETCH (2), .RVC (1'b1), .NR_ENTRIES (16), .FIFO_DEPTH (4)
  ) dut (
    .clk_i (clk), .rst_i (rst), .flush_bp_i (flush_bp), .debug_mode_i (dbg),
    .upd_valid_i (uv), .upd_pc_i (upc), .upd_taken_i (ut),
    .ram_rd_en_o (rd_en), .ram_rd_addr_o (rd_addr), .ram_rd_data_i (rd_data),
    .ram_we_o (we), .ram_wr_addr_o (wr_addr), .ram_wr_mask_o (mask), .ram_wr_data_o (wr_data),
    .flush_busy_o (busy)
`ifdef BHT_SCHED_STATS_EN
    , .stat_upd_o (s_upd), .stat_drop_o (s_drop)
`endif
  );
  typedef struct {int row; int col; bit taken;} upd_t;
  upd_t q[$];
  upd_t s1;
  bit s1_v, m_flush;
  int m_cnt, m_upd, m_drop, n_vec, n_err;
  int ctr [ROWS][2];
  logic [2:0] mem [ROWS][2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int sat(input int c, input bit t);
    return t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
  endfunction
  task automatic step();
    bit pop, upd, we_c, rde_c;
    int e_ctr, wa, ra;
    logic [1:0] mk;
    logic [5:0] wd;
    upd_t u;
    e_ctr = 0;
    @(negedge clk);
    chk("busy", busy, m_flush);
    pop = !m_flush && !flush_bp && q.size() > 0;
    upd = !m_flush && s1_v && !flush_bp;
    chk("rd_en", rd_en, pop);
    if (pop) chk("rd_addr", rd_addr, q[0].row);
    if (m_flush) begin
      chk("flush_we", we, 1);
      chk("flush_addr", wr_addr, m_cnt);
      chk("flush_mask", mask, 3);
      chk("flush_data", wr_data, 6'b010_010);
    end else if (upd) begin
      e_ctr = sat(ctr[s1.row][s1.col], s1.taken);
      chk("upd_we", we, 1);
      chk("upd_addr", wr_addr, s1.row);
      chk("upd_mask", mask, 1 << s1.col);
      chk("upd_data", (wr_data >> (3 * s1.col)) & 6'd7, 4 + e_ctr);
    end else chk("idle_we", we, 0);
    we_c = we; wa = wr_addr; mk = mask; wd = wr_data; rde_c = rd_en; ra = rd_addr;
    @(posedge clk);
    #1;
    rd_data = rde_c ? {mem[ra][1], mem[ra][0]} : 6'($urandom);
    for (int c = 0; c < 2; c++) if (we_c && mk[c]) mem[wa][c] = wd[3*c +: 3];
    if (m_flush) begin
      ctr[m_cnt][0] = 2;
      ctr[m_cnt][1] = 2;
    end else if (upd) begin
      ctr[s1.row][s1.col] = e_ctr;
      m_upd++;
    end
    s1_v = pop;
    if (pop) s1 = q.pop_front();
    if (flush_bp) q.delete();
    if (uv && !dbg) begin
      u.row = int'(upc[4:2]); u.col = int'(upc[1]); u.taken = ut;
      if (q.size() < 4) q.push_back(u);
      else m_drop++;
    end
    if (flush_bp) begin
      m_flush = 1; m_cnt = 0;
    end else if (m_flush) begin
      if (m_cnt == ROWS - 1) m_flush = 0;
      else m_cnt++;
    end
  endtask
  task automatic cyc(input bit v, input logic [31:0] pc, input bit t, input bit f, input bit d);
    uv = v; upc = pc; ut = t; flush_bp = f; dbg = d;
    step();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
  endtask
  task automatic poke(input int r, input int c, input int val);
    mem[r][c] = {1'b1, 2'(val)};
    ctr[r][c] = val;
  endtask
  initial begin
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < 2; c++) begin
      mem[r][c] = 3'($urandom);
      ctr[r][c] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_rd_en", rd_en, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m_flush = 1; m_cnt = 0; s1_v = 0;
    idle(10);
    cyc(1, 32'h1A, 1, 0, 0);
    idle(4);
    poke(6, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h1A, 1, 0, 0);
    idle(4);
    cyc(0, '0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, $urandom_range(0, 31), 1'($urandom), 0, 0);
    idle(16);
    cyc(1, 32'h0C, 1, 0, 0);
    idle(1);
    cyc(0, '0, 0, 1, 0);
    idle(12);
    cyc(0, '0, 0, 1, 0);
    idle(5);
    cyc(0, '0, 0, 1, 0);
    idle(12);
    for (int i = 0; i < 3; i++) cyc(1, $urandom_range(0, 31), 1, 0, 1);
    idle(3);
    poke(2, 0, 0);
    cyc(1, 32'h08, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) < 6, (i % 3 == 0) ? $urandom : $urandom_range(0, 7),
          1'($urandom), $urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
    idle(20);
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < 2; c++)
      chk("final_ctr", mem[r][c][1:0], ctr[r][c]);
`ifdef BHT_SCHED_STATS_EN
    chk("stat_upd", s_upd, m_upd);
    chk("stat_drop", s_drop, m_drop);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
